// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
//   Shared constants and types for the 33-tap FIR tap controller slice.
//   NUM_TAP  : number of taps / coefficients
//   COEFF_W  : signed coefficient width
//   IN_W     : signed input sample width
//   ADDR_W   : coefficient address width
//   fir_state_e : sequencer states (idle, streaming, draining)
// ---------------------------------------------------------------------------
package fir_pkg;

   localparam int NUM_TAP = 33;
   localparam int COEFF_W = 16;
   localparam int IN_W    = 3;
   localparam int ADDR_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fir_state_e;

   // True when a coefficient address names a real tap.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return addr < ADDR_W'(NUM_TAP);
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank
//   Shadow and active coefficient banks. Writes land in the shadow bank;
//   a copy request moves the whole registered shadow bank into the active
//   bank, which is what the datapath sees.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     wr_en       : shadow write strobe
//     wr_addr     : tap index of the write
//     wr_data     : coefficient value (two's complement, passed unchanged)
//     copy_en     : copy shadow -> active at the next edge
//     coeff       : active bank, tap k at [k*COEFF_W +: COEFF_W]
//     coeff_ok    : at least one copy since reset
//     addr_err    : sticky, a write addressed a tap that does not exist
// ---------------------------------------------------------------------------
module fir_coeff_bank
   import fir_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [COEFF_W-1:0]         wr_data,
   input  logic                       copy_en,
   output logic [NUM_TAP*COEFF_W-1:0] coeff,
   output logic                       coeff_ok,
   output logic                       addr_err
);

   logic [NUM_TAP-1:0][COEFF_W-1:0] shadow_q, shadow_d;
   logic [NUM_TAP-1:0][COEFF_W-1:0] active_q, active_d;
   logic                            coeff_ok_q, coeff_ok_d;
   logic                            addr_err_q, addr_err_d;
   logic                            wr_ok;
   logic                            wr_bad;

   // Write decode and copy. The copy reads shadow_q, so a write in the same
   // cycle as the copy only reaches the active bank on a later copy. A bad
   // write in the copy cycle still leaves the error flag set.
   always_comb begin
      wr_ok  = wr_en && addr_in_range(wr_addr);
      wr_bad = wr_en && !addr_in_range(wr_addr);

      shadow_d = shadow_q;
      for (int k = 0; k < NUM_TAP; k++) begin
         if (wr_ok && (wr_addr == ADDR_W'(k))) begin
            shadow_d[k] = wr_data;
         end
      end

      active_d   = copy_en ? shadow_q : active_q;
      coeff_ok_d = coeff_ok_q | copy_en;
      addr_err_d = (copy_en ? 1'b0 : addr_err_q) | wr_bad;
   end

   // Bank and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q   <= '0;
         active_q   <= '0;
         coeff_ok_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         coeff_ok_q <= coeff_ok_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign coeff    = active_q;
   assign coeff_ok = coeff_ok_q;
   assign addr_err = addr_err_q;

endmodule

// File: rtl/fir_tap_controller.sv
// ---------------------------------------------------------------------------
// fir_tap_controller
//   Sequencer and coefficient manager for the 33-tap transposed FIR
//   datapath. Paces samples at one per SAMPLE_DIV clocks, drives the
//   datapath sample (oFirIn) and accumulate enable (oEnAcc), drains the
//   pipeline with zeros on stop, and flags when the datapath output is valid.
//   Ports:
//     iClk_12M, iRsn             : clock, asynchronous active-low reset
//     iCoeffWr/Addr/Data         : shadow coefficient write
//     iCoeffCommit               : shadow -> active copy request
//     iStart, iStop              : enter streaming / leave through flush
//     iInValid, iInData, oInReady: one-entry sample buffer handshake
//     oFirIn, oEnAcc             : registered datapath drive
//     oOutValid                  : oEnAcc delayed by one clock
//     oCoeff, oCoeffOk           : active bank, at least one commit seen
//     oBusy                      : streaming or flushing
//     oUnderrun, oAddrErr        : sticky error flags
// ---------------------------------------------------------------------------
module fir_tap_controller
   import fir_pkg::*;
#(
   parameter int SAMPLE_DIV = 12
) (
   input  logic                       iClk_12M,
   input  logic                       iRsn,
   input  logic                       iCoeffWr,
   input  logic [ADDR_W-1:0]          iCoeffAddr,
   input  logic [COEFF_W-1:0]         iCoeffData,
   input  logic                       iCoeffCommit,
   input  logic                       iStart,
   input  logic                       iStop,
   input  logic                       iInValid,
   input  logic [IN_W-1:0]            iInData,
   output logic                       oInReady,
   output logic [IN_W-1:0]            oFirIn,
   output logic                       oEnAcc,
   output logic                       oOutValid,
   output logic [NUM_TAP*COEFF_W-1:0] oCoeff,
   output logic                       oCoeffOk,
   output logic                       oBusy,
   output logic                       oUnderrun,
   output logic                       oAddrErr
);

   localparam int                  TICK_W     = $clog2(SAMPLE_DIV);
   localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
   localparam int                  FLUSH_W    = $clog2(NUM_TAP);
   localparam logic [FLUSH_W-1:0]  FLUSH_LAST = FLUSH_W'(NUM_TAP - 1);

   fir_state_e          state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic                buf_valid_q, buf_valid_d;
   logic [IN_W-1:0]     buf_data_q, buf_data_d;
   logic [IN_W-1:0]     fir_in_q, fir_in_d;
   logic                en_acc_q, en_acc_d;
   logic                out_valid_q, out_valid_d;
   logic                underrun_q, underrun_d;
   logic                pending_q, pending_d;

   logic                tick;
   logic                xfer;
   logic                in_ready;
   logic                enter_idle;
   logic                commit_now;
   logic                coeff_ok;

   // Coefficient storage lives in its own block; the sequencer only decides
   // when the copy happens.
   fir_coeff_bank u_coeff_bank (
      .clk      (iClk_12M),
      .rst_n    (iRsn),
      .wr_en    (iCoeffWr),
      .wr_addr  (iCoeffAddr),
      .wr_data  (iCoeffData),
      .copy_en  (commit_now),
      .coeff    (oCoeff),
      .coeff_ok (coeff_ok),
      .addr_err (oAddrErr)
   );

   // Sequencer next-state logic. The tick counter keeps its phase across
   // RUN->FLUSH so flush pulses stay on the same sample grid. A sample still
   // sitting in the buffer when stop arrives is dropped: flush only feeds
   // zeros. A transfer in a tick cycle is only possible with an empty buffer,
   // so that tick underruns and the new sample waits for the next tick.
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      flush_cnt_d = flush_cnt_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      fir_in_d    = fir_in_q;
      en_acc_d    = 1'b0;
      out_valid_d = en_acc_q;
      underrun_d  = underrun_q;
      enter_idle  = 1'b0;

      in_ready = (state_q == ST_RUN) && !buf_valid_q;
      xfer     = iInValid && in_ready;
      tick     = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);

      case (state_q)
         ST_IDLE: begin
            tick_cnt_d = '0;
            if (iStart && coeff_ok) begin
               state_d    = ST_RUN;
               underrun_d = 1'b0;
            end
         end
         ST_RUN: begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            if (tick) begin
               en_acc_d = 1'b1;
               if (buf_valid_q) begin
                  fir_in_d    = buf_data_q;
                  buf_valid_d = 1'b0;
               end else begin
                  fir_in_d   = '0;
                  underrun_d = 1'b1;
               end
            end
            if (xfer) begin
               buf_valid_d = 1'b1;
               buf_data_d  = iInData;
            end
            if (iStop) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
               buf_valid_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            if (tick) begin
               en_acc_d = 1'b1;
               fir_in_d = '0;
               if (flush_cnt_q == FLUSH_LAST) begin
                  state_d     = ST_IDLE;
                  enter_idle  = 1'b1;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Commit handling. Outside IDLE a request is parked and released on the
   // edge that returns to IDLE, so the active bank never changes mid-stream.
   // A request arriving on that same edge is folded into the release.
   always_comb begin
      pending_d = pending_q;
      if (enter_idle) begin
         pending_d = 1'b0;
      end else if ((state_q != ST_IDLE) && iCoeffCommit) begin
         pending_d = 1'b1;
      end
      commit_now = ((state_q == ST_IDLE) && iCoeffCommit) ||
                   (enter_idle && (pending_q || iCoeffCommit));
   end

   // All sequencer state and registered outputs.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= '0;
         flush_cnt_q <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         fir_in_q    <= '0;
         en_acc_q    <= 1'b0;
         out_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
         fir_in_q    <= fir_in_d;
         en_acc_q    <= en_acc_d;
         out_valid_q <= out_valid_d;
         underrun_q  <= underrun_d;
         pending_q   <= pending_d;
      end
   end

   assign oInReady  = in_ready;
   assign oFirIn    = fir_in_q;
   assign oEnAcc    = en_acc_q;
   assign oOutValid = out_valid_q;
   assign oCoeffOk  = coeff_ok;
   assign oBusy     = (state_q != ST_IDLE);
   assign oUnderrun = underrun_q;

endmodule

// File: tb/tb_fir_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_controller
//   Randomized and directed stimulus for fir_tap_controller. A reference
//   model, written in terms of elapsed time since streaming started and a
//   one-slot sample queue, predicts every accumulate pulse and output-valid
//   cycle into scoreboards; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_fir_tap_controller;
   import fir_pkg::*;

   localparam int SAMPLE_DIV = 12;
   localparam int BANK_W     = NUM_TAP * COEFF_W;

   logic                 clk = 1'b0;
   logic                 iRsn;
   logic                 iCoeffWr;
   logic [ADDR_W-1:0]    iCoeffAddr;
   logic [COEFF_W-1:0]   iCoeffData;
   logic                 iCoeffCommit;
   logic                 iStart;
   logic                 iStop;
   logic                 iInValid;
   logic [IN_W-1:0]      iInData;
   logic                 oInReady;
   logic [IN_W-1:0]      oFirIn;
   logic                 oEnAcc;
   logic                 oOutValid;
   logic [BANK_W-1:0]    oCoeff;
   logic                 oCoeffOk;
   logic                 oBusy;
   logic                 oUnderrun;
   logic                 oAddrErr;

   fir_tap_controller #(.SAMPLE_DIV(SAMPLE_DIV)) dut (
      .iClk_12M     (clk),
      .iRsn         (iRsn),
      .iCoeffWr     (iCoeffWr),
      .iCoeffAddr   (iCoeffAddr),
      .iCoeffData   (iCoeffData),
      .iCoeffCommit (iCoeffCommit),
      .iStart       (iStart),
      .iStop        (iStop),
      .iInValid     (iInValid),
      .iInData      (iInData),
      .oInReady     (oInReady),
      .oFirIn       (oFirIn),
      .oEnAcc       (oEnAcc),
      .oOutValid    (oOutValid),
      .oCoeff       (oCoeff),
      .oCoeffOk     (oCoeffOk),
      .oBusy        (oBusy),
      .oUnderrun    (oUnderrun),
      .oAddrErr     (oAddrErr)
   );

   always #5 clk = ~clk;

   int     checks_total  = 0;
   int     checks_passed = 0;
   longint cyc           = 0;

   typedef struct {
      longint          at;
      logic [IN_W-1:0] fir;
   } pulse_t;

   pulse_t en_q[$];
   longint ov_q[$];

   // Reference model state: 0 idle, 1 streaming, 2 draining.
   int                 m_mode;
   longint             m_origin;
   int                 m_flush_ticks;
   logic [IN_W-1:0]    m_slot[$];
   logic [IN_W-1:0]    m_fir_in;
   bit                 m_underrun;
   bit                 m_ok;
   bit                 m_err;
   bit                 m_pending;
   logic [COEFF_W-1:0] m_shadow [NUM_TAP];
   logic [COEFF_W-1:0] m_active [NUM_TAP];

   task automatic checkOutput(input string name, input logic [BANK_W-1:0] actual,
                              input logic [BANK_W-1:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
   endtask

   function automatic logic [BANK_W-1:0] pack_active();
      logic [BANK_W-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_TAP; k++) r[k*COEFF_W +: COEFF_W] = m_active[k];
      return r;
   endfunction

   function automatic void modelReset();
      m_mode = 0; m_origin = 0; m_flush_ticks = 0;
      m_slot.delete();
      m_fir_in = '0; m_underrun = 0; m_ok = 0; m_err = 0; m_pending = 0;
      for (int k = 0; k < NUM_TAP; k++) begin
         m_shadow[k] = '0;
         m_active[k] = '0;
      end
      en_q.delete();
      ov_q.delete();
   endfunction

   // An accumulate pulse caused by the edge ending cycle cyc appears in the
   // next cycle; output-valid follows one cycle later.
   function automatic void emitPulse(input logic [IN_W-1:0] fir);
      pulse_t p;
      p.at  = cyc + 1;
      p.fir = fir;
      en_q.push_back(p);
      ov_q.push_back(cyc + 2);
      m_fir_in = fir;
   endfunction

   // Advance the model across one clock edge using the inputs held this cycle.
   function automatic void modelStep();
      bit ready = (m_mode == 1) && (m_slot.size() == 0);
      bit tick  = (m_mode != 0) && (((cyc - m_origin) % SAMPLE_DIV) == SAMPLE_DIV - 1);
      bit copy  = 0;
      int idx   = int'(iCoeffAddr);
      if (iCoeffCommit) begin
         if (m_mode == 0) copy = 1;
         else m_pending = 1;
      end
      if (m_mode == 0) begin
         if (iStart && m_ok) begin
            m_mode     = 1;
            m_origin   = cyc + 1;
            m_underrun = 0;
         end
      end else if (m_mode == 1) begin
         if (tick) begin
            if (m_slot.size() > 0) emitPulse(m_slot.pop_front());
            else begin
               emitPulse('0);
               m_underrun = 1;
            end
         end
         if (iInValid && ready) m_slot.push_back(iInData);
         if (iStop) begin
            m_mode        = 2;
            m_flush_ticks = 0;
            m_slot.delete();
         end
      end else begin
         if (tick) begin
            emitPulse('0);
            m_flush_ticks++;
            if (m_flush_ticks == NUM_TAP) begin
               m_mode = 0;
               if (m_pending) copy = 1;
               m_pending = 0;
            end
         end
      end
      if (copy) begin
         m_active = m_shadow;
         m_ok     = 1;
         m_err    = 0;
      end
      if (iCoeffWr) begin
         if (idx < NUM_TAP) m_shadow[idx] = iCoeffData;
         else m_err = 1;
      end
   endfunction

   task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [COEFF_W-1:0] data, input logic commit,
                                input logic start, input logic stop,
                                input logic valid, input logic [IN_W-1:0] din);
      iCoeffWr     = wr;
      iCoeffAddr   = addr;
      iCoeffData   = data;
      iCoeffCommit = commit;
      iStart       = start;
      iStop        = stop;
      iInValid     = valid;
      iInData      = din;
      @(posedge clk);
      modelStep();
      cyc++;
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, 0, 0, '0);
   endtask

   task automatic streamCycles(input int n, input logic [IN_W-1:0] din);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, 0, 0, 1, din);
   endtask

   task automatic resetDut();
      iRsn = 1'b0;
      #1;
      checkOutput("reset_outputs",
                  {oFirIn, oEnAcc, oOutValid, oInReady, oCoeffOk, oBusy, oUnderrun, oAddrErr}, '0);
      checkOutput("reset_coeff", oCoeff, '0);
      modelReset();
      repeat (3) begin
         @(posedge clk);
         cyc++;
      end
      #1 iRsn = 1'b1;
   endtask

   // Monitor: compare every cycle against the model and the scoreboards.
   always @(negedge clk) begin
      if (iRsn) begin
         bit exp_en;
         bit exp_ov;
         checkOutput("status_busy_ready_ok_err_unr",
                     {oBusy, oInReady, oCoeffOk, oAddrErr, oUnderrun},
                     {m_mode != 0, (m_mode == 1) && (m_slot.size() == 0), m_ok, m_err, m_underrun});
         checkOutput("fir_in_held", oFirIn, m_fir_in);
         checkOutput("coeff_bank", oCoeff, pack_active());
         exp_en = (en_q.size() > 0) && (en_q[0].at == cyc);
         checkOutput("en_acc", oEnAcc, exp_en);
         if (exp_en) begin
            checkOutput("fir_in_at_pulse", oFirIn, en_q[0].fir);
            void'(en_q.pop_front());
         end
         exp_ov = (ov_q.size() > 0) && (ov_q[0] == cyc);
         checkOutput("out_valid", oOutValid, exp_ov);
         if (exp_ov) void'(ov_q.pop_front());
      end
   end

   initial begin
      iRsn = 1'b1;
      iCoeffWr = 0; iCoeffAddr = '0; iCoeffData = '0; iCoeffCommit = 0;
      iStart = 0; iStop = 0; iInValid = 0; iInData = '0;
      modelReset();
      #2;
      resetDut();

      $display("[TB] start without coefficients");
      applyStimulus(0, '0, '0, 0, 1, 0, 0, '0);
      checkOutput("start_without_coeff", oBusy, 1'b0);

      $display("[TB] coefficient load and commit");
      for (int k = 0; k < NUM_TAP; k++) applyStimulus(1, ADDR_W'(k), COEFF_W'(k + 1), 0, 0, 0, 0, '0);
      applyStimulus(0, '0, '0, 1, 0, 0, 0, '0);
      checkOutput("tap32_after_commit", oCoeff[32*COEFF_W +: COEFF_W], 16'd33);
      checkOutput("coeff_ok_after_commit", oCoeffOk, 1'b1);

      $display("[TB] address error");
      applyStimulus(1, 6'd40, 16'h7FFF, 0, 0, 0, 0, '0);
      checkOutput("addr_err_set", oAddrErr, 1'b1);
      applyStimulus(0, '0, '0, 1, 0, 0, 0, '0);
      checkOutput("addr_err_cleared", oAddrErr, 1'b0);
      checkOutput("tap0_unchanged", oCoeff[COEFF_W-1:0], 16'd1);

      $display("[TB] streaming");
      applyStimulus(0, '0, '0, 0, 1, 0, 1, 3'd3);
      streamCycles(60, 3'd3);
      checkOutput("stream_fir_in", oFirIn, 3'd3);
      checkOutput("stream_no_underrun", oUnderrun, 1'b0);

      $display("[TB] underrun");
      for (int i = 0; i < 26; i++) applyStimulus(0, '0, '0, 0, 0, 0, 0, '0);
      checkOutput("underrun_set", oUnderrun, 1'b1);
      checkOutput("underrun_fir_in", oFirIn, 3'd0);
      streamCycles(30, 3'd3);
      checkOutput("underrun_sticky", oUnderrun, 1'b1);

      $display("[TB] commit during run then stop");
      for (int k = 0; k < NUM_TAP; k++) applyStimulus(1, ADDR_W'(k), COEFF_W'(-k), 0, 0, 0, 1, 3'd5);
      applyStimulus(0, '0, '0, 1, 0, 0, 1, 3'd5);
      checkOutput("coeff_held_in_run", oCoeff[32*COEFF_W +: COEFF_W], 16'd33);
      applyStimulus(0, '0, '0, 0, 0, 1, 0, '0);
      checkOutput("busy_in_flush", oBusy, 1'b1);
      idleCycles(NUM_TAP * SAMPLE_DIV + 20);
      checkOutput("idle_after_flush", oBusy, 1'b0);
      checkOutput("tap32_after_flush", oCoeff[32*COEFF_W +: COEFF_W], 16'hFFE0);
      checkOutput("tap1_after_flush", oCoeff[COEFF_W +: COEFF_W], 16'hFFFF);

      applyStimulus(0, '0, '0, 0, 1, 0, 1, 3'd2);
      checkOutput("underrun_cleared_on_start", oUnderrun, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(0, 7) == 0, ADDR_W'($urandom_range(0, 40)),
                       COEFF_W'($urandom), $urandom_range(0, 39) == 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                       $urandom_range(0, 3) != 0, IN_W'($urandom));
      end
      applyStimulus(0, '0, '0, 0, 0, 1, 0, '0);
      idleCycles(NUM_TAP * SAMPLE_DIV + 20);

      $display("[TB] reset mid-run");
      applyStimulus(0, '0, '0, 0, 1, 0, 1, 3'd1);
      streamCycles(30, 3'd1);
      checkOutput("busy_before_reset", oBusy, 1'b1);
      resetDut();
      checkOutput("coeff_ok_after_reset", oCoeffOk, 1'b0);
      checkOutput("busy_after_reset", oBusy, 1'b0);
      applyStimulus(0, '0, '0, 0, 1, 0, 0, '0);
      checkOutput("start_ignored_after_reset", oBusy, 1'b0);
      idleCycles(5);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
